// File: rtl/hopfield_update_ctrl.sv
// Sweep controller for the 20-neuron Hopfield recall datapath (prediction, defined below).
// Define HOPFIELD_CTRL_EARLY_EXIT_EN to stop as soon as a full sweep produces no changes.

module prediction (
    input  logic [199:0] weights_packed,
    input  logic [39:0]  xalt_packed,
    output logic [9:0]   y
);
    logic [9:0] acc;
    logic [9:0] w;

    // Neuron codes: 01=+1, 11=-1, 10=-2, 00=0; the sum wraps at 10 bits.
    always_comb begin
        acc = '0;
        w   = '0;
        for (int j = 0; j < 20; j++) begin
            w = weights_packed[10*j +: 10];
            unique case (xalt_packed[2*j +: 2])
                2'b01:   acc = acc + w;
                2'b11:   acc = acc - w;
                2'b10:   acc = acc - {w[8:0], 1'b0};
                default: acc = acc;
            endcase
        end
        y = acc;
    end
endmodule

module hopfield_update_ctrl #(
    parameter int unsigned MAX_SWEEPS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [39:0]  init_state,
    output logic         w_row_req,
    output logic [4:0]   w_row_addr,
    input  logic         w_row_valid,
    input  logic [199:0] w_row_data,
    output logic         busy,
    output logic         done,
    output logic         converged,
    output logic [4:0]   sweep_count,
    output logic [39:0]  state_out
);
    localparam int unsigned N = 20;

`ifdef HOPFIELD_CTRL_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        EVAL,
        DONE
    } fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [39:0]    neur_q, neur_d;
    logic [199:0]   row_q, row_d;
    logic [4:0]     idx_q, idx_d;
    logic [4:0]     sweeps_q, sweeps_d;
    logic           changed_q, changed_d;
    logic           conv_q, conv_d;

    logic [9:0]     y;
    logic [1:0]     old_val;
    logic [1:0]     new_val;
    logic           chg_any;
    logic           last_idx;
    logic           at_limit;

    prediction u_prediction (
        .weights_packed (row_q),
        .xalt_packed    (neur_q),
        .y              (y)
    );

    always_comb begin
        old_val  = neur_q[{idx_q, 1'b0} +: 2];
        new_val  = y[9] ? 2'b11 : ((y != 10'd0) ? 2'b01 : old_val);
        chg_any  = changed_q | (new_val != old_val);
        last_idx = (idx_q == 5'(N - 1));
        at_limit = ((32'(sweeps_q) + 32'd1) == MAX_SWEEPS);
    end

    always_comb begin
        fsm_d     = fsm_q;
        neur_d    = neur_q;
        row_d     = row_q;
        idx_d     = idx_q;
        sweeps_d  = sweeps_q;
        changed_d = changed_q;
        conv_d    = conv_q;

        unique case (fsm_q)
            IDLE: begin
                if (start) fsm_d = LOAD;
            end
            LOAD: begin
                // -2 is folded to -1 so the datapath only ever sees bipolar or zero neurons.
                for (int j = 0; j < 20; j++) begin
                    neur_d[2*j +: 2] = (init_state[2*j +: 2] == 2'b10) ? 2'b11
                                                                       : init_state[2*j +: 2];
                end
                idx_d     = '0;
                sweeps_d  = '0;
                changed_d = 1'b0;
                conv_d    = 1'b0;
                fsm_d     = FETCH;
            end
            FETCH: begin
                if (w_row_valid) begin
                    row_d = w_row_data;
                    fsm_d = EVAL;
                end
            end
            EVAL: begin
                neur_d[{idx_q, 1'b0} +: 2] = new_val;
                if (!last_idx) begin
                    idx_d     = idx_q + 5'd1;
                    changed_d = chg_any;
                    fsm_d     = FETCH;
                end else begin
                    sweeps_d = sweeps_q + 5'd1;
                    if (EarlyExit && !chg_any) begin
                        conv_d = 1'b1;
                        fsm_d  = DONE;
                    end else if (at_limit) begin
                        conv_d = !chg_any;
                        fsm_d  = DONE;
                    end else begin
                        idx_d     = '0;
                        changed_d = 1'b0;
                        fsm_d     = FETCH;
                    end
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            neur_q    <= '0;
            row_q     <= '0;
            idx_q     <= '0;
            sweeps_q  <= '0;
            changed_q <= 1'b0;
            conv_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            neur_q    <= neur_d;
            row_q     <= row_d;
            idx_q     <= idx_d;
            sweeps_q  <= sweeps_d;
            changed_q <= changed_d;
            conv_q    <= conv_d;
        end
    end

    assign w_row_req   = (fsm_q == FETCH);
    assign w_row_addr  = idx_q;
    assign busy        = (fsm_q == LOAD) || (fsm_q == FETCH) || (fsm_q == EVAL);
    assign done        = (fsm_q == DONE);
    assign converged   = conv_q;
    assign sweep_count = sweeps_q;
    assign state_out   = neur_q;
endmodule

// File: tb/tb_hopfield_update_ctrl.sv
// Randomized and directed bench for hopfield_update_ctrl against an array-based recall model.
// Follows HOPFIELD_CTRL_EARLY_EXIT_EN the same way the design does.

module tb_hopfield_update_ctrl;
    localparam int N    = 20;
    localparam int MAXS = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [39:0]  init_state;
    logic         w_row_req;
    logic [4:0]   w_row_addr;
    logic         w_row_valid;
    logic [199:0] w_row_data;
    logic         busy;
    logic         done;
    logic         converged;
    logic [4:0]   sweep_count;
    logic [39:0]  state_out;

    hopfield_update_ctrl #(.MAX_SWEEPS(MAXS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .init_state  (init_state),
        .w_row_req   (w_row_req),
        .w_row_addr  (w_row_addr),
        .w_row_valid (w_row_valid),
        .w_row_data  (w_row_data),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .sweep_count (sweep_count),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         wm [N][N];
    logic [1:0] init_code [N];
    bit         early;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference recall: sequential sign updates over plain integers, 10-bit wrapped sums.
    task automatic model(output logic [39:0] fin, output int sw, output bit conv);
        int x [N];
        int s;
        int yv;
        int nv;
        bit ch;
        for (int i = 0; i < N; i++)
            x[i] = (init_code[i] == 2'b00) ? 0 : ((init_code[i] == 2'b01) ? 1 : -1);
        sw = 0;
        ch = 1'b0;
        do begin
            ch = 1'b0;
            for (int i = 0; i < N; i++) begin
                s = 0;
                for (int j = 0; j < N; j++) s += wm[i][j] * x[j];
                yv = s & 1023;
                if (yv >= 512) yv -= 1024;
                nv = (yv > 0) ? 1 : ((yv < 0) ? -1 : x[i]);
                if (nv != x[i]) ch = 1'b1;
                x[i] = nv;
            end
            sw++;
        end while (!(early && !ch) && sw < MAXS);
        conv = !ch;
        for (int i = 0; i < N; i++)
            fin[2*i +: 2] = (x[i] == 1) ? 2'b01 : ((x[i] == -1) ? 2'b11 : 2'b00);
    endtask

    function automatic logic [199:0] row_of(input int a);
        logic [199:0] r;
        int           v;
        r = '0;
        if (a >= 0 && a < N) begin
            for (int j = 0; j < N; j++) begin
                v = wm[a][j];
                r[10*j +: 10] = v[9:0];
            end
        end
        return r;
    endfunction

    task automatic set_weights(input int kind);
        int p [N];
        for (int i = 0; i < N; i++) p[i] = (i % 2 == 0) ? 1 : -1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (kind)
                    1: wm[i][j] = (i == j) ? 0 : p[i] * p[j];
                    3: wm[i][j] = int'($urandom_range(0, 1023)) - 512;
                    default: wm[i][j] = 0;
                endcase
            end
        end
        if (kind == 2) begin
            wm[0][1] = 1;
            wm[1][0] = -1;
        end
        if (kind == 4) begin
            for (int i = 0; i < N; i++)
                for (int j = i + 1; j < N; j++) begin
                    wm[i][j] = int'($urandom_range(0, 14)) - 7;
                    wm[j][i] = wm[i][j];
                end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_conv"}, 64'(converged), 64'd0);
        chk({tag, "_sweeps"}, 64'(sweep_count), 64'd0);
        chk({tag, "_state"}, 64'(state_out), 64'd0);
        chk({tag, "_req"}, 64'(w_row_req), 64'd0);
        chk({tag, "_addr"}, 64'(w_row_addr), 64'd0);
    endtask

    // One recall: serves rows with a fixed latency, optionally pulses a stray start or resets.
    task automatic run(input int lat, input int ign_at, input int rst_at);
        logic [39:0] ef;
        int          es;
        bit          ec;
        int          eedge;
        int          edges;
        bit          got;
        bit          prev;
        int          cnt;
        int          rows;
        logic [4:0]  raddr;
        logic [39:0] snap;
        model(ef, es, ec);
        eedge = 1 + (2 + lat) * N * es;
        for (int i = 0; i < N; i++) init_state[2*i +: 2] = init_code[i];
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        chk("busy_in_load", 64'(busy), 64'd1);
        edges = 0; got = 1'b0; prev = 1'b0; cnt = 0; rows = 0; raddr = '0; snap = '0;
        while (!got && edges < 2000) begin
            if (edges == rst_at) begin
                chk("busy_before_reset", 64'(busy), 64'd1);
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_reset");
                w_row_valid = 1'b0;
                start = 1'b0;
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            if (done) begin
                got = 1'b1;
            end else begin
                if (w_row_req) begin
                    if (!prev) begin
                        cnt = 0;
                        raddr = w_row_addr;
                        snap = state_out;
                        chk("row_addr", 64'(w_row_addr), 64'(rows % N));
                    end else begin
                        cnt++;
                        chk("addr_hold", 64'(w_row_addr), 64'(raddr));
                        chk("state_hold", 64'(state_out), 64'(snap));
                    end
                end
                prev = w_row_req;
                w_row_valid = w_row_req && (cnt >= lat);
                w_row_data = w_row_req ? row_of(int'(w_row_addr)) : '0;
                if (w_row_valid) rows++;
                start = (edges == ign_at);
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        w_row_valid = 1'b0;
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        if (got) begin
            chk("done_edge", 64'(edges), 64'(eedge));
            chk("converged", 64'(converged), 64'(ec));
            chk("sweep_count", 64'(sweep_count), 64'(es));
            chk("state_out", 64'(state_out), 64'(ef));
            chk("busy_in_done", 64'(busy), 64'd0);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("conv_held", 64'(converged), 64'(ec));
            chk("sweeps_held", 64'(sweep_count), 64'(es));
        end
    endtask

    initial begin
`ifdef HOPFIELD_CTRL_EARLY_EXIT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        rst_n = 1'b1; start = 1'b0; w_row_valid = 1'b0; w_row_data = '0; init_state = '0;
        #2 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Zero weights, all +1: settles in the first sweep (or runs to the limit without early exit).
        set_weights(0);
        for (int i = 0; i < N; i++) init_code[i] = 2'b01;
        run(0, -1, -1);

        // Stored alternating pattern with neuron 7 flipped.
        set_weights(1);
        for (int i = 0; i < N; i++) init_code[i] = (i % 2 == 0) ? 2'b01 : 2'b11;
        init_code[7] = 2'b01;
        run(0, -1, -1);

        // Asymmetric pair oscillates for every sweep.
        set_weights(2);
        for (int i = 0; i < N; i++) init_code[i] = 2'b01;
        run(0, -1, -1);

        // Row backpressure of three cycles.
        set_weights(0);
        run(3, -1, -1);

        // Reset during the EVAL of neuron 5, then a normal run.
        run(0, -1, 12);
        @(negedge clk);
        run(0, -1, -1);

        // Stray start while busy, then a fresh start.
        set_weights(1);
        for (int i = 0; i < N; i++) init_code[i] = (i % 2 == 0) ? 2'b01 : 2'b11;
        init_code[7] = 2'b01;
        run(1, 30, -1);
        run(0, -1, -1);

        // Random symmetric and fully random weights with random initial codes and latencies.
        for (int t = 0; t < 6; t++) begin
            set_weights((t < 4) ? 4 : 3);
            for (int i = 0; i < N; i++) init_code[i] = 2'($urandom_range(0, 3));
            run(int'($urandom_range(0, 2)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hopfield_update_ctrl.md
# hopfield_update_ctrl

Sequencing controller for the 20-neuron recall datapath (`prediction`, instantiated internally). It loads an initial neuron state and fetches one 200-bit weight row per neuron from an external weight store. It updates neurons asynchronously in index order 0..19 using the sign of the datapath output, and repeats full sweeps until no neuron changes or a sweep limit is reached. It sits between the weight memory and the host/top-level FSM that starts a recall and reads back the settled state.

## Interface
- N, 20: neuron count; fixed by the datapath, not overridable.
- MAX_SWEEPS, 16: sweep limit, legal range 1..31.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- init_state  in  40  initial neurons, 2-bit signed each, neuron j at [2j+:2].
- w_row_req  out  1  weight row request.
- w_row_addr  out  5  row index requested (= current neuron).
- w_row_valid  in  1  row data valid; sampled while w_row_req=1.
- w_row_data  in  200  row, W[idx][j] at [10j+:10], signed.
- busy  out  1  high from LOAD through EVAL.
- done  out  1  one-cycle completion pulse.
- converged  out  1  last completed sweep had zero changes; valid when done=1, held until next start.
- sweep_count  out  5  completed sweeps; held after done.
- state_out  out  40  current neuron state register (also drives datapath xalt_packed).

## Operation
- Internal registers: state_reg[39:0], row_reg[199:0], idx[4:0], sweeps[4:0], changed.
- Datapath input wiring: weights_packed = row_reg, xalt_packed = state_reg; y is combinational.
- FSM states:
  - IDLE: waits for start=1. On start, goes to LOAD.
  - LOAD: state_reg <= init_state, with each 2'b10 replaced by 2'b11. Clears idx, sweeps and changed. Goes to FETCH.
  - FETCH: w_row_req=1, w_row_addr=idx. On w_row_valid=1, row_reg <= w_row_data and the FSM goes to EVAL. Otherwise it stays; the address is held stable.
  - EVAL: computes the new value of neuron idx from y: y>0 gives 2'b01, y<0 (y[9]=1) gives 2'b11, y==0 keeps the old value. Sets changed if the value differs. Then branches:
    - idx<N-1: idx++ and go to FETCH.
    - idx==N-1: sweeps++. If changed=0, go to DONE with converged=1. Else if sweeps+1==MAX_SWEEPS, go to DONE with converged=0. Else clear idx and changed, and go to FETCH.
  - DONE: done=1 for one cycle, then IDLE.
- Updates are sequential: neuron i sees the already-updated values of neurons <i within the same sweep.
- y is the 10-bit wrapped sum from the datapath; the controller does no saturation.
- A start pulse outside IDLE is ignored; there is no abort input.
- 2'b00 neurons are legal. Such a neuron contributes 0 to the sum and stays 0 until it sees a nonzero y.

## Timing
- Reset (async assert): state IDLE, busy=0, done=0, converged=0, sweep_count=0, state_out=0, w_row_req=0, w_row_addr=0, row_reg=0.
  - Reset during any state aborts immediately.
  - w_row_req drops asynchronously.
- start sampled at edge 0: LOAD is in the cycle after edge 0, FETCH idx0 after edge 1.
- Each neuron takes 1 FETCH cycle plus k wait cycles, plus 1 EVAL cycle.
- With w_row_valid tied high, done is high in the cycle after edge 1+2·N·S, where S is the number of sweeps executed (S=1: after edge 41).
- busy falls in the DONE cycle.
- state_out updates on the EVAL edge.

## Configuration
- HOPFIELD_CTRL_EARLY_EXIT_EN defined: a sweep with zero changes terminates the run, as described in Operation.
- HOPFIELD_CTRL_EARLY_EXIT_EN undefined: always runs exactly MAX_SWEEPS sweeps. converged still reports whether the final sweep had zero changes.

## Test plan
- All-zero weights, init all 2'b01, valid tied high: done after edge 41, converged=1, sweep_count=1, state_out unchanged.
- Hebbian weights W[i][j]=p_i·p_j (i≠j, diagonal 0), p alternating +1/−1, init = p with neuron 7 flipped: neuron 7 is restored in sweep 1; done with converged=1, sweep_count=2, state_out=p.
- Asymmetric W[0][1]=+1, W[1][0]=−1, all other weights 0, init all +1: neurons 0/1 oscillate every sweep; done with converged=0, sweep_count=16.
- Backpressure: w_row_valid delayed 3 cycles per row. w_row_addr is held stable, no state change occurs before valid, and the zero-weight case finishes after edge 1+5·20=101.
- rst_n pulsed low during sweep 1 EVAL: all outputs at reset values immediately. start asserted while busy is ignored; a fresh start then runs normally.
- Macro undefined, zero-weight case: 16 sweeps, done after edge 641, converged=1, sweep_count=16.
